// File: rtl/ldm_stm_sequencer.sv
// Sequences one ARM LDM/STM block transfer: CALC, one XFER per accepted memory cycle, optional base WB, DONE pulse.
// Busy for N+2(+1 with writeback) cycles plus one per mem_ready_in stall; commands are ignored while busy.
module ldm_stm_sequencer (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic        is_load_in,
  input  logic [15:0] reg_list_in,
  input  logic [3:0]  base_reg_in,
  input  logic [31:0] base_val_in,
  input  logic        p_in,
  input  logic        u_in,
  input  logic        w_in,
  input  logic        mem_ready_in,
  output logic        busy_out,
  output logic [3:0]  reg_addr_out,
  output logic        reg_rd_en_out,
  output logic        reg_wr_en_out,
  output logic [31:0] mem_addr_out,
  output logic        mem_rd_en_out,
  output logic        mem_wr_en_out,
  output logic        base_wb_en_out,
  output logic [31:0] base_wb_data_out,
  output logic        done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_XFER,
    S_WB,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        is_load_q;
  logic [15:0] list_q;
  logic [31:0] base_val_q;
  logic        p_q, u_q, w_q;
  logic        wb_sup_q;
  logic [31:0] addr_q;
  logic [31:0] wb_data_q;

  logic [4:0]  cnt;
  logic [31:0] four_n;
  logic [3:0]  low_idx;
  logic [15:0] list_next;
  logic [31:0] start_addr;

  always_comb begin
    cnt     = 5'd0;
    low_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, list_q[i]};
    end
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) low_idx = i[3:0];
    end
  end

  assign four_n    = {25'd0, cnt, 2'b00};
  // Clearing the lowest set bit walks the list in ascending register order.
  assign list_next = list_q & (list_q - 16'd1);

  always_comb begin
    start_addr = base_val_q;
    case ({p_q, u_q})
      2'b01:   start_addr = base_val_q;
      2'b11:   start_addr = base_val_q + 32'd4;
      2'b00:   start_addr = base_val_q - four_n + 32'd4;
      default: start_addr = base_val_q - four_n;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      is_load_q  <= 1'b0;
      list_q     <= 16'd0;
      base_val_q <= 32'd0;
      p_q        <= 1'b0;
      u_q        <= 1'b0;
      w_q        <= 1'b0;
      wb_sup_q   <= 1'b0;
      addr_q     <= 32'd0;
      wb_data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            is_load_q  <= is_load_in;
            list_q     <= reg_list_in;
            base_val_q <= base_val_in;
            p_q        <= p_in;
            u_q        <= u_in;
            w_q        <= w_in;
            // A load into the base register overrides the writeback.
            wb_sup_q   <= is_load_in & reg_list_in[base_reg_in];
          end
        end
        S_CALC: begin
          addr_q    <= start_addr;
          wb_data_q <= u_q ? (base_val_q + four_n) : (base_val_q - four_n);
        end
        S_XFER: begin
          if (mem_ready_in) begin
            list_q <= list_next;
            addr_q <= addr_q + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    busy_out       = (state_q != S_IDLE);
    reg_addr_out   = 4'd0;
    mem_addr_out   = 32'd0;
    reg_rd_en_out  = 1'b0;
    reg_wr_en_out  = 1'b0;
    mem_rd_en_out  = 1'b0;
    mem_wr_en_out  = 1'b0;
    base_wb_en_out = 1'b0;
    done_out       = 1'b0;
    case (state_q)
      S_IDLE: if (start_in) state_d = S_CALC;
      S_CALC: state_d = (cnt == 5'd0) ? S_DONE : S_XFER;
      S_XFER: begin
        reg_addr_out  = low_idx;
        mem_addr_out  = addr_q;
        mem_rd_en_out = is_load_q;
        mem_wr_en_out = ~is_load_q;
        reg_rd_en_out = ~is_load_q;
        reg_wr_en_out = is_load_q & mem_ready_in;
        if (mem_ready_in && (list_next == 16'd0)) begin
          state_d = (w_q && !wb_sup_q) ? S_WB : S_DONE;
        end
      end
      S_WB: begin
        base_wb_en_out = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign base_wb_data_out = wb_data_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed and randomized block-transfer commands checked cycle by cycle against an address/list model.
module tb_ldm_stm_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic        is_load_in;
  logic [15:0] reg_list_in;
  logic [3:0]  base_reg_in;
  logic [31:0] base_val_in;
  logic        p_in, u_in, w_in;
  logic        mem_ready_in;
  logic        busy_out;
  logic [3:0]  reg_addr_out;
  logic        reg_rd_en_out, reg_wr_en_out;
  logic [31:0] mem_addr_out;
  logic        mem_rd_en_out, mem_wr_en_out;
  logic        base_wb_en_out;
  logic [31:0] base_wb_data_out;
  logic        done_out;

  int ncmp = 0;
  int nfail = 0;

  ldm_stm_sequencer dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .is_load_in(is_load_in),
    .reg_list_in(reg_list_in), .base_reg_in(base_reg_in), .base_val_in(base_val_in),
    .p_in(p_in), .u_in(u_in), .w_in(w_in), .mem_ready_in(mem_ready_in),
    .busy_out(busy_out), .reg_addr_out(reg_addr_out), .reg_rd_en_out(reg_rd_en_out),
    .reg_wr_en_out(reg_wr_en_out), .mem_addr_out(mem_addr_out), .mem_rd_en_out(mem_rd_en_out),
    .mem_wr_en_out(mem_wr_en_out), .base_wb_en_out(base_wb_en_out),
    .base_wb_data_out(base_wb_data_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Control vector: {busy, mem_rd, mem_wr, reg_rd, reg_wr, base_wb_en, done}
  function automatic logic [6:0] ctl();
    return {busy_out, mem_rd_en_out, mem_wr_en_out, reg_rd_en_out, reg_wr_en_out,
            base_wb_en_out, done_out};
  endfunction

  task automatic noise_inputs();
    start_in    = 1'($urandom);
    is_load_in  = 1'($urandom);
    reg_list_in = 16'($urandom);
    base_reg_in = 4'($urandom);
    base_val_in = $urandom;
    p_in        = 1'($urandom);
    u_in        = 1'($urandom);
    w_in        = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {25'd0, ctl()}, 32'd0);
    chk({tag, "_reg"}, {28'd0, reg_addr_out}, 32'd0);
    chk({tag, "_addr"}, mem_addr_out, 32'd0);
    chk({tag, "_wbd"}, base_wb_data_out, 32'd0);
  endtask

  // Called in an IDLE cycle at posedge+2; returns in the IDLE cycle after DONE
  // (or the cycle after a reset when rst_k >= 0).
  task automatic run_cmd(input bit ld, input logic [15:0] lst, input logic [3:0] breg,
                         input logic [31:0] bval, input bit p, input bit u, input bit w,
                         input int stall_k, input int stall_n, input bit rnd, input bit noise,
                         input int rst_k);
    int          regs[$];
    int          n;
    int          stalls;
    logic [31:0] fn, lo, wbv;
    bit          wb_exp;
    regs.delete();
    for (int r = 0; r < 16; r++) if (lst[r]) regs.push_back(r);
    n   = regs.size();
    fn  = 32'(n * 4);
    if (u) lo = p ? bval + 32'd4 : bval;
    else   lo = p ? bval - fn : bval - fn + 32'd4;
    wbv    = u ? bval + fn : bval - fn;
    wb_exp = w && (n > 0) && !(ld && lst[breg]);

    start_in = 1'b1; is_load_in = ld; reg_list_in = lst; base_reg_in = breg;
    base_val_in = bval; p_in = p; u_in = u; w_in = w;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    if (noise) noise_inputs();
    mem_ready_in = 1'($urandom);
    #1;
    chk("calc_ctl", {25'd0, ctl()}, 32'b1000000);

    for (int k = 0; k < n; k++) begin
      stalls = (k == stall_k) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= stalls; s++) begin
        @(posedge clk_in); #1;
        if (noise) noise_inputs();
        mem_ready_in = (s == stalls);
        if (k == rst_k && s == stalls) reset_in = 1'b1;
        #1;
        chk("xfer_reg", {28'd0, reg_addr_out}, 32'(regs[k]));
        chk("xfer_addr", mem_addr_out, lo + 32'(k * 4));
        chk("xfer_ctl", {25'd0, ctl()},
            {25'd0, 1'b1, ld, !ld, !ld, ld && (s == stalls), 1'b0, 1'b0});
      end
      if (k == rst_k) begin
        @(posedge clk_in); #1;
        reset_in = 1'b0; start_in = 1'b0; mem_ready_in = 1'b0;
        #1;
        check_all_zero("after_reset");
        return;
      end
    end

    if (wb_exp) begin
      @(posedge clk_in); #1;
      if (noise) noise_inputs();
      mem_ready_in = 1'($urandom);
      #1;
      chk("wb_ctl", {25'd0, ctl()}, 32'b1000010);
      chk("wb_data", base_wb_data_out, wbv);
    end

    @(posedge clk_in); #1;
    if (noise) noise_inputs();
    mem_ready_in = 1'($urandom);
    #1;
    chk("done_ctl", {25'd0, ctl()}, 32'b1000001);

    @(posedge clk_in); #1;
    start_in = 1'b0; mem_ready_in = 1'b0;
    #1;
    chk("idle_ctl", {25'd0, ctl()}, 32'd0);
  endtask

  initial begin
    reset_in = 1'b1; start_in = 1'b0; is_load_in = 1'b0; reg_list_in = 16'd0;
    base_reg_in = 4'd0; base_val_in = 32'd0; p_in = 1'b0; u_in = 1'b0; w_in = 1'b0;
    mem_ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1; reset_in = 1'b0; #1;
    check_all_zero("reset");

    // LDM IA, R13 base, writeback
    run_cmd(1, 16'h000B, 4'd13, 32'h0000_1000, 0, 1, 1, -1, 0, 0, 0, -1);
    // STM DB and DA with start_in noise during the transfer
    run_cmd(0, 16'hC000, 4'd13, 32'h0000_2000, 1, 0, 1, -1, 0, 0, 1, -1);
    run_cmd(0, 16'hC000, 4'd13, 32'h0000_2000, 0, 0, 1, -1, 0, 0, 1, -1);
    // LDM IB with two stall cycles on the second register
    run_cmd(1, 16'h0006, 4'd13, 32'h0000_0100, 1, 1, 1, 1, 2, 0, 0, -1);
    // Empty list, and LDM with base in the list (writeback suppressed)
    run_cmd(1, 16'h0000, 4'd13, 32'h0000_3000, 0, 1, 1, -1, 0, 0, 0, -1);
    run_cmd(1, 16'h0004, 4'd2, 32'h0000_4000, 0, 1, 1, -1, 0, 0, 0, -1);
    // STM with base in the list still writes back
    run_cmd(0, 16'h0104, 4'd8, 32'h0000_5000, 0, 1, 1, -1, 0, 0, 0, -1);
    // Address wrap
    run_cmd(1, 16'h0003, 4'd13, 32'hFFFF_FFFC, 0, 1, 1, -1, 0, 0, 0, -1);
    // Reset during the second transfer of a 4-register LDM
    run_cmd(1, 16'h00F0, 4'd13, 32'h0000_6000, 0, 1, 1, -1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #2;
      chk("post_reset_idle", {25'd0, ctl()}, 32'd0);
    end
    run_cmd(1, 16'h00F0, 4'd13, 32'h0000_6000, 0, 1, 1, -1, 0, 0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      run_cmd(1'($urandom), 16'($urandom) & 16'($urandom), 4'($urandom), $urandom,
              1'($urandom), 1'($urandom), 1'($urandom), -1, 0, 1, 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
